if_fetch_queue: RTL and testbench

//  Fetch-stage buffer between the PC register / instruction ROM and the decode stage.

---
 rtl/if_fetch_queue_pkg.sv | 12 +
 rtl/if_fetch_queue_mem.sv | 26 ++
 rtl/if_fetch_queue.sv | 90 +++++++++
 tb/tb_if_fetch_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage constants: reset/enable polarities, bus widths and stall encoding.
package if_fetch_queue_pkg;

    localparam logic        RST_ENABLE  = 1'b1;
    localparam logic        CHIP_ENABLE = 1'b1;
    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        STOP        = 1'b1;
    localparam logic        NO_STOP     = 1'b0;

endpackage

// File: rtl/if_fetch_queue_mem.sv
// DEPTH-entry register array holding {pc, inst} pairs; one write port, one async read port.
module if_fetch_queue_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// In-order fetch queue between PC/ROM and decode with valid/ready handshake, full stall and flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      pc_i,
    input  logic                   ce_i,
    input  logic [DATA_W-1:0]      inst_i,
    input  logic                   flush_i,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [ADDR_W-1:0]      id_pc,
    output logic [DATA_W-1:0]      id_inst,
    output logic                   stall_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;
    logic [ENT_W-1:0] head_s;

    if_fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata ({pc_i, inst_i}),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Stall depends on the count register alone so the PC path never sees id_ready.
    assign stall_o  = (count_r == CNT_W'(DEPTH)) ? STOP : NO_STOP;
    assign id_valid = (count_r != {CNT_W{1'b0}});
    assign count_o  = count_r;

    assign push_s = (ce_i == CHIP_ENABLE) & (stall_o == NO_STOP) & ~flush_i & (rst != RST_ENABLE);
    assign pop_s  = id_valid & id_ready & ~flush_i;

    // Head presentation: zero (NOP) whenever the queue is empty.
    always_comb begin
        id_pc   = ADDR_W'(ZERO_WORD);
        id_inst = DATA_W'(ZERO_WORD);
        if (id_valid) begin
            id_pc   = head_s[ENT_W-1:DATA_W];
            id_inst = head_s[DATA_W-1:0];
        end else begin
            id_pc   = ADDR_W'(ZERO_WORD);
            id_inst = DATA_W'(ZERO_WORD);
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and random checks of if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        stall_o;
    logic [1:0]  count_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [63:0] mq[$];
    logic [31:0] popped[$];

    if_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_i     (pc_i),
        .ce_i     (ce_i),
        .inst_i   (inst_i),
        .flush_i  (flush_i),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .stall_o  (stall_o),
        .count_o  (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {pc,inst}; full blocks fetch, flush/reset empty it.
    always @(posedge clk) begin
        if (rst || flush_i) begin
            mq.delete();
        end else if (ce_i && mq.size() < DEPTH) begin
            if (mq.size() != 0 && id_ready) popped.push_back(mq.pop_front() >> 32);
            mq.push_back({pc_i, inst_i});
        end else if (mq.size() != 0 && id_ready) begin
            popped.push_back(mq.pop_front() >> 32);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", 64'(id_valid), 64'(mq.size() != 0));
            chk("pc",    64'(id_pc),    (mq.size() != 0) ? 64'(mq[0][63:32]) : 64'h0);
            chk("inst",  64'(id_inst),  (mq.size() != 0) ? 64'(mq[0][31:0])  : 64'h0);
            chk("stall", 64'(stall_o),  64'(mq.size() == DEPTH));
            chk("count", 64'(count_o),  64'(mq.size()));
        end
    end

    task automatic step(input logic ce, input logic [31:0] pc, input logic fl, input logic rdy);
        ce_i = ce; pc_i = pc; inst_i = ~pc; flush_i = fl; id_ready = rdy;
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic v, input logic [31:0] pc,
                           input logic st, input logic [1:0] cnt);
        chk({name, "_valid"}, 64'(id_valid), 64'(v));
        chk({name, "_pc"},    64'(id_pc),    64'(pc));
        chk({name, "_stall"}, 64'(stall_o),  64'(st));
        chk({name, "_count"}, 64'(count_o),  64'(cnt));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 2'd0);
        chk("reset_inst", 64'(id_inst), 64'h0);
        cmp_en = 1'b1;

        // 1: streaming 0,4,8 with ready high
        popped.delete();
        step(1'b1, 32'h0, 1'b0, 1'b1);
        chk_out("t1_first", 1'b1, 32'h0, 1'b0, 2'd1);
        chk("t1_inst", 64'(id_inst), 64'hFFFF_FFFF);
        step(1'b1, 32'h4, 1'b0, 1'b1);
        chk_out("t1_second", 1'b1, 32'h4, 1'b0, 2'd1);
        step(1'b1, 32'h8, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_out("t1_drained", 1'b0, 32'h0, 1'b0, 2'd0);
        chk("t1_order_n", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("t1_pop0", 64'(popped[0]), 64'h0);
            chk("t1_pop1", 64'(popped[1]), 64'h4);
            chk("t1_pop2", 64'(popped[2]), 64'h8);
        end

        // 2/3: fill, blocked fetch, full pop without push
        popped.delete();
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'h14, 1'b0, 1'b0);
        chk_out("t2_full", 1'b1, 32'h10, 1'b1, 2'd2);
        step(1'b1, 32'h18, 1'b0, 1'b0);
        chk_out("t2_blocked", 1'b1, 32'h10, 1'b1, 2'd2);
        step(1'b1, 32'h18, 1'b0, 1'b1);
        chk_out("t3_popfull", 1'b1, 32'h14, 1'b0, 2'd1);
        step(1'b1, 32'h18, 1'b0, 1'b0);
        chk_out("t2_accept", 1'b1, 32'h14, 1'b1, 2'd2);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_order_n", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("t2_pop0", 64'(popped[0]), 64'h10);
            chk("t2_pop1", 64'(popped[1]), 64'h14);
            chk("t2_pop2", 64'(popped[2]), 64'h18);
        end

        // 4: flush discards queue and concurrent fetch
        step(1'b1, 32'h20, 1'b0, 1'b0);
        step(1'b1, 32'h24, 1'b0, 1'b0);
        step(1'b1, 32'h28, 1'b1, 1'b1);
        chk_out("t4_flush", 1'b0, 32'h0, 1'b0, 2'd0);
        step(1'b1, 32'h100, 1'b0, 1'b0);
        chk_out("t4_after", 1'b1, 32'h100, 1'b0, 2'd1);

        // 5: reset with full queue and flush; then pointer wrap
        step(1'b1, 32'h104, 1'b0, 1'b0);
        chk_out("t5_full", 1'b1, 32'h100, 1'b1, 2'd2);
        rst = 1'b1;
        step(1'b1, 32'h108, 1'b1, 1'b1);
        rst = 1'b0;
        chk_out("t5_reset", 1'b0, 32'h0, 1'b0, 2'd0);
        popped.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_wrap_n", 64'(popped.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < popped.size()) chk("t5_wrap", 64'(popped[i]), 64'h200 + 64'(4 * i));
        end

        // 6: random traffic, model compare every cycle
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 2) != 0);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
